// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type and elaboration-time helpers (bit reversal, twiddle
// generation, saturation) for the iterative radix-2 FFT.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } fft_state_t;

    localparam int  MAX_LOG2N = 10;
    localparam real PI        = 3.14159265358979323846;

    // Unity in the Q1.(TW_W-2) twiddle format.
    function automatic int tw_one(input int tw_w);
        return 1 << (tw_w - 2);
    endfunction

    function automatic int bitrev(input int idx, input int log2n);
        int r;
        r = 0;
        for (int b = 0; b < MAX_LOG2N; b++) begin
            if (b < log2n) begin
                r = (r << 1) | ((idx >> b) & 1);
            end
        end
        return r;
    endfunction

    // W_N^k component, rounded to nearest; imag_part returns -sin so the ROM holds W directly.
    function automatic int twiddle(input int k, input int log2n, input int tw_w, input bit imag_part);
        real ang;
        real v;
        ang = 2.0 * PI * $itor(k) / $itor(1 << log2n);
        v   = $itor(tw_one(tw_w)) * (imag_part ? -$sin(ang) : $cos(ang));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic longint saturate(input longint value, input int dw);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// fft_bfly: combinational radix-2 DIT butterfly -- complex multiply with per-product
// rounding, add/sub, arithmetic >>>1 scaling and saturation to DW bits.
module fft_bfly
    import fft_pkg::*;
#(
    parameter int DW   = 16,
    parameter int TW_W = 16
) (
    input  logic signed [DW-1:0]   a_re_i,
    input  logic signed [DW-1:0]   a_im_i,
    input  logic signed [DW-1:0]   b_re_i,
    input  logic signed [DW-1:0]   b_im_i,
    input  logic signed [TW_W-1:0] w_re_i,
    input  logic signed [TW_W-1:0] w_im_i,
    output logic signed [DW-1:0]   a_re_o,
    output logic signed [DW-1:0]   a_im_o,
    output logic signed [DW-1:0]   b_re_o,
    output logic signed [DW-1:0]   b_im_o
);

    localparam int PW = DW + TW_W;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] HALF_LSB = SW'(1) <<< (TW_W - 3);

    function automatic logic signed [SW-1:0] round_prod(input logic signed [PW-1:0] p);
        return (SW'(p) + HALF_LSB) >>> (TW_W - 2);
    endfunction

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0] t_re, t_im;
    logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;

    always_comb begin
        p_rr   = PW'(b_re_i) * PW'(w_re_i);
        p_ii   = PW'(b_im_i) * PW'(w_im_i);
        p_ri   = PW'(b_re_i) * PW'(w_im_i);
        p_ir   = PW'(b_im_i) * PW'(w_re_i);
        t_re   = round_prod(p_rr) - round_prod(p_ii);
        t_im   = round_prod(p_ri) + round_prod(p_ir);
        sum_re = SW'(a_re_i) + t_re;
        sum_im = SW'(a_im_i) + t_im;
        dif_re = SW'(a_re_i) - t_re;
        dif_im = SW'(a_im_i) - t_im;
        // The >>>1 floors toward -inf; saturation only matters for rotated full-scale inputs.
        a_re_o = DW'(saturate(longint'(sum_re >>> 1), DW));
        a_im_o = DW'(saturate(longint'(sum_im >>> 1), DW));
        b_re_o = DW'(saturate(longint'(dif_re >>> 1), DW));
        b_im_o = DW'(saturate(longint'(dif_im >>> 1), DW));
    end

endmodule

// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: N-point iterative radix-2 DIT FFT, one in-place butterfly per clock, 1/N scaling.
// Define FFT_INVERSE_EN to add the per-frame 'inverse' input (conjugate twiddles, IFFT/N).
module fft_radix2_iter
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int DW    = 16,
    parameter int TW_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic                 out_last,
    output logic                 busy
`ifdef FFT_INVERSE_EN
    ,
    input  logic                 inverse
`endif
);

    localparam int N      = 1 << LOG2N;
    localparam int HALF_N = N / 2;

    localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] IDX_ONE    = LOG2N'(1);
    localparam logic [LOG2N-2:0] LAST_BFLY  = (LOG2N-1)'(HALF_N - 1);
    localparam logic [LOG2N-2:0] BFLY_ONE   = (LOG2N-1)'(1);
    localparam logic [3:0]       LAST_STAGE = 4'(LOG2N - 1);

    logic signed [DW-1:0]   mem_re_q [N];
    logic signed [DW-1:0]   mem_im_q [N];
    logic signed [TW_W-1:0] tw_re    [HALF_N];
    logic signed [TW_W-1:0] tw_im    [HALF_N];

    fft_state_t           state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic signed [DW-1:0] out_real_q, out_real_d;
    logic signed [DW-1:0] out_imag_q, out_imag_d;
    logic [LOG2N-1:0]     load_cnt_q, load_cnt_d;
    logic [LOG2N-1:0]     bin_q, bin_d;
    logic [LOG2N-2:0]     bfly_q, bfly_d;
    logic [3:0]           stage_q, stage_d;

    logic                   load_fire;
    logic [LOG2N-1:0]       load_addr, span, low_mask, j_ext, idx_a, idx_b;
    logic [LOG2N-2:0]       tw_k;
    logic signed [TW_W-1:0] w_re, w_im;
    logic signed [DW-1:0]   a_re_n, a_im_n, b_re_n, b_im_n;

    for (genvar k = 0; k < HALF_N; k++) begin : g_tw_rom
        localparam int TW_RE = twiddle(k, LOG2N, TW_W, 1'b0);
        localparam int TW_IM = twiddle(k, LOG2N, TW_W, 1'b1);
        assign tw_re[k] = TW_W'(TW_RE);
        assign tw_im[k] = TW_W'(TW_IM);
    end

`ifdef FFT_INVERSE_EN
    logic inv_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_q <= 1'b0;
        end else if (load_fire && load_cnt_q == '0) begin
            inv_q <= inverse;
        end
    end
`endif

    assign load_fire = (state_q == LOAD) && in_valid && in_ready_q;

    // Butterfly j of stage s: a = insert a 0 at bit s of j, b = a + span, k = (j mod span) << (LOG2N-1-s).
    always_comb begin
        load_addr = LOG2N'(bitrev(int'(load_cnt_q), LOG2N));
        span      = IDX_ONE << stage_q;
        low_mask  = span - IDX_ONE;
        j_ext     = {1'b0, bfly_q};
        idx_a     = ((j_ext & ~low_mask) << 1) | (j_ext & low_mask);
        idx_b     = idx_a | span;
        tw_k      = (LOG2N-1)'((j_ext & low_mask) << (LAST_STAGE - stage_q));
        w_re      = tw_re[tw_k];
`ifdef FFT_INVERSE_EN
        w_im      = inv_q ? -tw_im[tw_k] : tw_im[tw_k];
`else
        w_im      = tw_im[tw_k];
`endif
    end

    fft_bfly #(
        .DW   (DW),
        .TW_W (TW_W)
    ) u_bfly (
        .a_re_i (mem_re_q[idx_a]),
        .a_im_i (mem_im_q[idx_a]),
        .b_re_i (mem_re_q[idx_b]),
        .b_im_i (mem_im_q[idx_b]),
        .w_re_i (w_re),
        .w_im_i (w_im),
        .a_re_o (a_re_n),
        .a_im_o (a_im_n),
        .b_re_o (b_re_n),
        .b_im_o (b_im_n)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        load_cnt_d  = load_cnt_q;
        bin_d       = bin_q;
        bfly_d      = bfly_q;
        stage_d     = stage_q;

        unique case (state_q)
            LOAD: begin
                in_ready_d = 1'b1;
                if (load_fire) begin
                    load_cnt_d = load_cnt_q + IDX_ONE;
                    if (load_cnt_q == LAST_IDX) begin
                        in_ready_d = 1'b0;
                        state_d    = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                bfly_d = bfly_q + BFLY_ONE;
                if (bfly_q == LAST_BFLY) begin
                    stage_d = stage_q + 4'd1;
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                // The first bin is fetched one cycle after entry; later bins advance on handshake only.
                if (!out_valid_q || out_ready) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = LOAD;
                    end else begin
                        out_valid_d = 1'b1;
                        out_real_d  = mem_re_q[bin_q];
                        out_imag_d  = mem_im_q[bin_q];
                        out_last_d  = (bin_q == LAST_IDX);
                        bin_d       = bin_q + IDX_ONE;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            load_cnt_q  <= '0;
            bin_q       <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            load_cnt_q  <= load_cnt_d;
            bin_q       <= bin_d;
            bfly_q      <= bfly_d;
            stage_q     <= stage_d;
        end
    end

    // NOTE: the sample array has no reset; LOAD overwrites every entry before COMPUTE reads any.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem_re_q[load_addr] <= in_real;
            mem_im_q[load_addr] <= in_imag;
        end else if (state_q == COMPUTE) begin
            mem_re_q[idx_a] <= a_re_n;
            mem_im_q[idx_a] <= a_im_n;
            mem_re_q[idx_b] <= b_re_n;
            mem_im_q[idx_b] <= b_im_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign busy      = (state_q == COMPUTE) || (state_q == UNLOAD);

endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb_fft_radix2_iter: directed, self-checking bench for the 8-point iterative FFT.
module tb_fft_radix2_iter;

    localparam int LOG2N = 3;
    localparam int DW    = 16;
    localparam int TW_W  = 16;
    localparam int N     = 1 << LOG2N;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] in_real   = '0;
    logic signed [DW-1:0] in_imag   = '0;
    logic                 in_ready, out_valid, out_last, busy;
    logic signed [DW-1:0] out_real, out_imag;
`ifdef FFT_INVERSE_EN
    logic                 inverse   = 1'b0;
`endif

    int checks        = 0;
    int failures      = 0;
    int cyc           = 0;
    int last_beat_cyc = 0;
    int frame_re [N];
    int frame_im [N];
    int exp_re   [N];
    int exp_im   [N];

    fft_radix2_iter #(
        .LOG2N (LOG2N),
        .DW    (DW),
        .TW_W  (TW_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last),
        .busy      (busy)
`ifdef FFT_INVERSE_EN
        ,
        .inverse   (inverse)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        int guard;
        for (int n = 0; n < N; n++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_real  = DW'(frame_re[n]);
            in_imag  = DW'(frame_im[n]);
            guard = 0;
            while (in_ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            check($sformatf("load_ready_beat%0d", n), in_ready, 1);
            tick();
        end
        in_valid      = 1'b0;
        in_real       = '0;
        in_imag       = '0;
        last_beat_cyc = cyc;
    endtask

    task automatic recv_frame(input bit stall, input bit chk_lat, input string name);
        int guard;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        check({name, "_first_valid"}, out_valid, 1);
        if (chk_lat) check({name, "_latency"}, cyc - last_beat_cyc, LOG2N * N / 2 + 1);
        for (int b = 0; b < N; b++) begin
            if (stall) begin
                out_ready = 1'b0;
                tick();
                tick();
            end
            check($sformatf("%s_bin%0d_valid", name, b), out_valid, 1);
            check($sformatf("%s_bin%0d_re", name, b), out_real, exp_re[b]);
            check($sformatf("%s_bin%0d_im", name, b), out_imag, exp_im[b]);
            check($sformatf("%s_bin%0d_last", name, b), out_last, (b == N - 1) ? 1 : 0);
            check($sformatf("%s_bin%0d_in_ready", name, b), in_ready, 0);
            out_ready = 1'b1;
            tick();
        end
        check({name, "_done_valid"}, out_valid, 0);
        check({name, "_done_in_ready"}, in_ready, 1);
    endtask

    task automatic set_impulse();
        for (int n = 0; n < N; n++) begin
            frame_re[n] = (n == 0) ? 1000 : 0;
            frame_im[n] = 0;
            exp_re[n]   = 125;
            exp_im[n]   = 0;
        end
    endtask

    initial begin
        // Reset state while reset is held.
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        reset = 1'b0;
        check("release_in_ready_before_edge", in_ready, 0);
        tick();
        check("release_in_ready_after_edge", in_ready, 1);

        // 1: impulse, with latency check.
        set_impulse();
        send_frame(1'b0);
        check("impulse_busy", busy, 1);
        check("impulse_in_ready_compute", in_ready, 0);
        recv_frame(1'b0, 1'b1, "impulse");

        // 2: DC.
        for (int n = 0; n < N; n++) begin
            frame_re[n] = 800;
            frame_im[n] = 0;
            exp_re[n]   = (n == 0) ? 800 : 0;
            exp_im[n]   = 0;
        end
        send_frame(1'b0);
        recv_frame(1'b0, 1'b1, "dc");

        // 3: tone at bin 2 (cos, period 4).
        for (int n = 0; n < N; n++) begin
            frame_re[n] = (n % 2 != 0) ? 0 : ((n % 4 == 0) ? 1000 : -1000);
            frame_im[n] = 0;
            exp_re[n]   = (n == 2 || n == 6) ? 500 : 0;
            exp_im[n]   = 0;
        end
        send_frame(1'b0);
        recv_frame(1'b0, 1'b1, "tone");

        // 4: backpressure on both streams.
        set_impulse();
        send_frame(1'b1);
        recv_frame(1'b1, 1'b0, "bp");

        // 5: full-scale DC on both components.
        for (int n = 0; n < N; n++) begin
            frame_re[n] = 32767;
            frame_im[n] = 32767;
            exp_re[n]   = (n == 0) ? 32767 : 0;
            exp_im[n]   = (n == 0) ? 32767 : 0;
        end
        send_frame(1'b0);
        recv_frame(1'b0, 1'b1, "sat");

        // 6: reset 5 cycles into COMPUTE, then a clean impulse frame.
        set_impulse();
        send_frame(1'b0);
        repeat (5) tick();
        check("midrst_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_last", out_last, 0);
        tick();
        tick();
        reset = 1'b0;
        check("midrst_release_in_ready_before", in_ready, 0);
        tick();
        check("midrst_release_in_ready_after", in_ready, 1);
        send_frame(1'b0);
        recv_frame(1'b0, 1'b1, "post_rst");

`ifdef FFT_INVERSE_EN
        inverse = 1'b1;
        set_impulse();
        send_frame(1'b0);
        inverse = 1'b0;
        recv_frame(1'b0, 1'b1, "inverse");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
